iceb_pmod_7seg_scan: RTL and testbench

- Parametrised N-digit multiplexed 7-segment driver: the next generation of the two-digit hex PMOD display driver.
- Scans NUM_DIGITS hex digits in time-multiplexed fashion, with:
  - a configurable dwell per digit and an anti-ghost blanking window;
  - a frame-coherent snapshot of the displayed value;
  - leading-zero suppression, per-digit blank and decimal-point control;
  - 16-level PWM brightness;
  - selectable output polarity.
- Sits between CPU debug/output registers and the board PMOD pins.

---
 rtl/iceb_pmod_7seg_scan.sv | 148 ++++++++++++++
 tb/tb_iceb_pmod_7seg_scan.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iceb_pmod_7seg_scan.sv
// Time-multiplexed N-digit hex 7-segment driver.
// Adds a per-frame input snapshot, leading-zero suppression, per-digit blank and dp, PWM brightness, and selectable output polarity.
module iceb_pmod_7seg_scan #(
    parameter int unsigned NUM_DIGITS     = 2,
    parameter int unsigned DWELL_BITS     = 8,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic                    lz_suppress_i,
    input  logic [3:0]              bright_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   dig_o,
    output logic                    frame_o
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_INV =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [DWELL_BITS-1:0]   r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_value;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [NUM_DIGITS-1:0]   r_sh_blank;
    logic                    r_sh_lz;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic                    r_frame;

    logic                  w_frame_start;
    logic                  w_upper_zero;
    logic [NUM_DIGITS-1:0] w_supp;
    logic [3:0]            w_nib;
    logic                  w_dp_sel;
    logic                  w_blank_sel;
    logic                  w_supp_sel;
    logic                  w_on;
    logic                  w_pwm;
    logic                  w_lit;
    logic [6:0]            w_hex;
    logic [NUM_DIGITS-1:0] w_dig_hot;

    assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

    // Digit k (k>0) is suppressed when it and every more significant nibble are zero.
    always_comb begin
        w_upper_zero = 1'b1;
        w_supp       = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            w_upper_zero = w_upper_zero & (r_sh_value[4*k +: 4] == 4'd0);
            if (k > 0) begin
                w_supp[k] = r_sh_lz & w_upper_zero;
            end
        end
    end

    // Select the shadow state of the digit currently being scanned.
    always_comb begin
        w_nib       = 4'd0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_supp_sel  = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (IDX_W'(k) == r_idx) begin
                w_nib       = r_sh_value[4*k +: 4];
                w_dp_sel    = r_sh_dp[k];
                w_blank_sel = r_sh_blank[k];
                w_supp_sel  = w_supp[k];
            end
        end
    end

    always_comb begin
        w_hex = 7'b0000000;
        case (w_nib)
            4'h0: w_hex = 7'b1111110;
            4'h1: w_hex = 7'b0110000;
            4'h2: w_hex = 7'b1101101;
            4'h3: w_hex = 7'b1111001;
            4'h4: w_hex = 7'b0110011;
            4'h5: w_hex = 7'b1011011;
            4'h6: w_hex = 7'b1011111;
            4'h7: w_hex = 7'b1110000;
            4'h8: w_hex = 7'b1111111;
            4'h9: w_hex = 7'b1111011;
            4'hA: w_hex = 7'b1110111;
            4'hB: w_hex = 7'b0011111;
            4'hC: w_hex = 7'b1001110;
            4'hD: w_hex = 7'b0111101;
            4'hE: w_hex = 7'b1001111;
            4'hF: w_hex = 7'b1000111;
            default: w_hex = 7'b0000000;
        endcase
    end

    // Anti-ghost blanking first, then PWM gates the remainder of the dwell.
    assign w_on      = (r_cnt >= DWELL_BITS'(BLANK_CYCLES));
    assign w_pwm     = (bright_i == 4'hF) || (r_cnt[DWELL_BITS-1 -: 4] < bright_i);
    assign w_lit     = w_on & ~w_blank_sel & ~w_supp_sel & w_pwm;
    assign w_dig_hot = NUM_DIGITS'(1) << r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= '0;
            r_sh_lz    <= 1'b0;
            r_seg      <= SEG_INV;
            r_dp       <= DP_INV;
            r_dig      <= DIG_INV;
            r_frame    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_start) begin
                r_sh_value <= value_i;
                r_sh_dp    <= dp_i;
                r_sh_blank <= blank_i;
                r_sh_lz    <= lz_suppress_i;
            end
            r_seg   <= (w_lit ? w_hex : 7'd0) ^ SEG_INV;
            r_dp    <= (w_lit & w_dp_sel) ^ DP_INV;
            r_dig   <= (w_lit ? w_dig_hot : '0) ^ DIG_INV;
            r_frame <= w_frame_start;
        end
    end

    assign seg_o   = r_seg;
    assign dp_o    = r_dp;
    assign dig_o   = r_dig;
    assign frame_o = r_frame;

endmodule

// File: tb/tb_iceb_pmod_7seg_scan.sv
// Directed bench for iceb_pmod_7seg_scan: 4 digits, 32-cycle dwell, 2 blank cycles, active-low outputs.
module tb_iceb_pmod_7seg_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic        lz_suppress_i;
    logic [3:0]  bright_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  dig_o;
    logic        frame_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] s_val;
    logic [3:0]  s_dp;
    logic [3:0]  s_bl;
    logic        s_lz;

    iceb_pmod_7seg_scan #(
        .NUM_DIGITS    (4),
        .DWELL_BITS    (5),
        .BLANK_CYCLES  (2),
        .SEG_ACTIVE_LOW(1),
        .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .value_i      (value_i),
        .dp_i         (dp_i),
        .blank_i      (blank_i),
        .lz_suppress_i(lz_suppress_i),
        .bright_i     (bright_i),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .dig_o        (dig_o),
        .frame_o      (frame_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Expected {dig, seg, dp} for frame position p (0..127), active-low.
    function automatic logic [11:0] model(input int p, input logic [15:0] v, input logic [3:0] dpv,
                                          input logic [3:0] bl, input logic lz, input logic [3:0] br);
        int  idx;
        int  c;
        logic lit;
        idx = p / 32;
        c   = p % 32;
        lit = (c >= 2) && !bl[idx] && ((br == 4'd15) || ((c / 2) < int'(br)));
        if (lz && idx > 0 && ((v >> (4 * idx)) == 16'd0)) lit = 1'b0;
        if (lit) return {~(4'b0001 << idx), ~hex7(v[4*idx +: 4]), ~dpv[idx]};
        return {4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
    endtask

    task automatic set_defaults();
        value_i       = 16'h1234;
        dp_i          = 4'b0000;
        blank_i       = 4'b0000;
        lz_suppress_i = 1'b0;
        bright_i      = 4'd15;
    endtask

    task automatic test_reset();
        set_defaults();
        rst_n = 1'b0;
        repeat (5) step();
        checks++;
        if (seg_o !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg_o); end
        checks++;
        if (dp_o !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_o); end
        checks++;
        if (dig_o !== 4'hF) begin failures++; $display("FAIL reset_dig got=%b exp=1111", dig_o); end
        checks++;
        if (frame_o !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_o); end
        rst_n = 1'b1;
        checks++;
        if (frame_o !== 1'b0) begin failures++; $display("FAIL release_frame0 got=%b exp=0", frame_o); end
        step();
        checks++;
        if (frame_o !== 1'b1 || dig_o !== 4'hF) begin
            failures++; $display("FAIL edge1 frame=%b dig=%b exp frame=1 dig=1111", frame_o, dig_o);
        end
        step();
        checks++;
        if (frame_o !== 1'b0 || dig_o !== 4'hF) begin
            failures++; $display("FAIL edge2 frame=%b dig=%b exp frame=0 dig=1111", frame_o, dig_o);
        end
        step();
        checks++;
        if (dig_o !== 4'b1110 || seg_o !== 7'b1001100 || dp_o !== 1'b1) begin
            failures++;
            $display("FAIL edge3 dig=%b seg=%b dp=%b exp dig=1110 seg=1001100 dp=1", dig_o, seg_o, dp_o);
        end
    endtask

    task automatic test_scan();
        logic [11:0] e;
        int lit0   = 0;
        int frames = 0;
        set_defaults();
        reset_dut();
        for (int p = 0; p < 256; p++) begin
            step();
            if (p % 128 == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
            e = model(p % 128, s_val, s_dp, s_bl, s_lz, bright_i);
            if (dig_o === 4'b1110) lit0++;
            if (frame_o === 1'b1) frames++;
            checks++;
            if ({dig_o, seg_o, dp_o, frame_o} !== {e, (p % 128) == 0}) begin
                failures++;
                $display("FAIL scan p=%0d got dig=%b seg=%b dp=%b frame=%b exp=%b_%b", p, dig_o, seg_o, dp_o, frame_o, e, (p % 128) == 0);
            end
        end
        checks++;
        if (lit0 !== 60) begin failures++; $display("FAIL scan_dwell0 got=%0d exp=60", lit0); end
        checks++;
        if (frames !== 2) begin failures++; $display("FAIL scan_frames got=%0d exp=2", frames); end
    endtask

    task automatic test_tearing();
        logic [11:0] e;
        set_defaults();
        reset_dut();
        for (int p = 0; p < 256; p++) begin
            if (p == 2 * 32 + 5) value_i = 16'hABCD;
            step();
            if (p % 128 == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
            e = model(p % 128, s_val, s_dp, s_bl, s_lz, bright_i);
            checks++;
            if ({dig_o, seg_o, dp_o} !== e) begin
                failures++;
                $display("FAIL tear p=%0d got dig=%b seg=%b dp=%b exp=%b", p, dig_o, seg_o, dp_o, e);
            end
            if (p == 3 * 32 + 10) begin
                checks++;
                if (dig_o !== 4'b0111 || seg_o !== 7'b1001111) begin
                    failures++; $display("FAIL tear_old dig=%b seg=%b exp dig=0111 seg=1001111", dig_o, seg_o);
                end
            end
            if (p == 128 + 10) begin
                checks++;
                if (dig_o !== 4'b1110 || seg_o !== 7'b1000010) begin
                    failures++; $display("FAIL tear_new dig=%b seg=%b exp dig=1110 seg=1000010", dig_o, seg_o);
                end
            end
        end
    endtask

    task automatic test_lz_blank_dp();
        logic [15:0] t_val [5] = '{16'h0050, 16'h0000, 16'h1234, 16'h1234, 16'h0050};
        logic        t_lz  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0]  t_bl  [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic [3:0]  t_dp  [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0001, 4'b0100};
        int          t_lit [5] = '{60, 30, 90, 120, 60};
        int          t_dpl [5] = '{0, 0, 0, 30, 0};
        logic [11:0] e;
        int lit;
        int dpl;
        for (int t = 0; t < 5; t++) begin
            set_defaults();
            value_i = t_val[t]; lz_suppress_i = t_lz[t]; blank_i = t_bl[t]; dp_i = t_dp[t];
            reset_dut();
            lit = 0;
            dpl = 0;
            for (int p = 0; p < 128; p++) begin
                step();
                if (p == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
                e = model(p, s_val, s_dp, s_bl, s_lz, bright_i);
                if (dig_o !== 4'hF) lit++;
                if (dp_o === 1'b0) dpl++;
                checks++;
                if ({dig_o, seg_o, dp_o} !== e) begin
                    failures++;
                    $display("FAIL lz case=%0d p=%0d got dig=%b seg=%b dp=%b exp=%b", t, p, dig_o, seg_o, dp_o, e);
                end
            end
            checks++;
            if (lit !== t_lit[t]) begin failures++; $display("FAIL lz_lit case=%0d got=%0d exp=%0d", t, lit, t_lit[t]); end
            checks++;
            if (dpl !== t_dpl[t]) begin failures++; $display("FAIL lz_dp case=%0d got=%0d exp=%0d", t, dpl, t_dpl[t]); end
        end
    endtask

    task automatic test_brightness();
        logic [3:0]  t_br  [4] = '{4'd4, 4'd0, 4'd1, 4'd14};
        int          t_lit [4] = '{24, 0, 0, 104};
        logic [11:0] e;
        int lit;
        for (int t = 0; t < 4; t++) begin
            set_defaults();
            bright_i = t_br[t];
            reset_dut();
            lit = 0;
            for (int p = 0; p < 128; p++) begin
                step();
                if (p == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
                e = model(p, s_val, s_dp, s_bl, s_lz, bright_i);
                if (dig_o !== 4'hF) lit++;
                checks++;
                if ({dig_o, seg_o, dp_o} !== e) begin
                    failures++;
                    $display("FAIL bright=%0d p=%0d got dig=%b seg=%b dp=%b exp=%b", t_br[t], p, dig_o, seg_o, dp_o, e);
                end
            end
            checks++;
            if (lit !== t_lit[t]) begin failures++; $display("FAIL bright_lit br=%0d got=%0d exp=%0d", t_br[t], lit, t_lit[t]); end
        end
    endtask

    task automatic test_midscan_reset();
        logic [11:0] e;
        set_defaults();
        reset_dut();
        for (int p = 0; p < 75; p++) begin
            step();
            if (p == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
            e = model(p, s_val, s_dp, s_bl, s_lz, bright_i);
            checks++;
            if ({dig_o, seg_o, dp_o} !== e) begin
                failures++;
                $display("FAIL mid_pre p=%0d got dig=%b seg=%b dp=%b exp=%b", p, dig_o, seg_o, dp_o, e);
            end
        end
        value_i = 16'hABCD;
        rst_n   = 1'b0;
        step();
        checks++;
        if (dig_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset dig=%b seg=%b dp=%b frame=%b exp 1111 1111111 1 0", dig_o, seg_o, dp_o, frame_o);
        end
        rst_n = 1'b1;
        for (int p = 0; p < 128; p++) begin
            step();
            if (p == 0) begin s_val = value_i; s_dp = dp_i; s_bl = blank_i; s_lz = lz_suppress_i; end
            e = model(p, s_val, s_dp, s_bl, s_lz, bright_i);
            checks++;
            if ({dig_o, seg_o, dp_o, frame_o} !== {e, p == 0}) begin
                failures++;
                $display("FAIL mid_post p=%0d got dig=%b seg=%b dp=%b frame=%b exp=%b", p, dig_o, seg_o, dp_o, frame_o, e);
            end
            if (p == 10) begin
                checks++;
                if (dig_o !== 4'b1110 || seg_o !== 7'b1000010) begin
                    failures++; $display("FAIL mid_digit0 dig=%b seg=%b exp dig=1110 seg=1000010", dig_o, seg_o);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_defaults();
        test_reset();
        test_scan();
        test_tearing();
        test_lz_blank_dp();
        test_brightness();
        test_midscan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
